// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler
// Owns the register-file write port and the per-register hazard scoreboard.
// ALU and LSU writeback requests share one registered write port; issue is
// stalled while any source or the destination register has a write pending.
// Optional build macro REGFILE_WB_RR_ARB_EN selects round-robin arbitration
// between ALU and LSU; without it the LSU always has priority.
module regfile_wb_scheduler #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_iss_valid,
    input  logic [ADDR_WIDTH-1:0]       i_iss_rs1,
    input  logic [ADDR_WIDTH-1:0]       i_iss_rs2,
    input  logic [ADDR_WIDTH-1:0]       i_iss_rd,
    input  logic                        i_iss_wr,
    output logic                        o_iss_ready,
    input  logic                        i_alu_valid,
    input  logic [ADDR_WIDTH-1:0]       i_alu_rd,
    input  logic [DATA_WIDTH-1:0]       i_alu_data,
    output logic                        o_alu_ready,
    input  logic                        i_lsu_valid,
    input  logic [ADDR_WIDTH-1:0]       i_lsu_rd,
    input  logic [DATA_WIDTH-1:0]       i_lsu_data,
    output logic                        o_lsu_ready,
    output logic                        o_we,
    output logic [ADDR_WIDTH-1:0]       o_wr_address,
    output logic [DATA_WIDTH-1:0]       o_wr_data,
    output logic [(1<<ADDR_WIDTH)-1:0]  o_busy,
    output logic                        o_idle,
    output logic                        o_err
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] wr_address_q, wr_address_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  err_q, err_d;

    logic                  pick_lsu, pick_alu;
    logic                  alu_gnt, lsu_gnt, wb_valid;
    logic [ADDR_WIDTH-1:0] wb_rd;
    logic [DATA_WIDTH-1:0] wb_data;
    logic                  iss_ready, iss_fire;

`ifdef REGFILE_WB_RR_ARB_EN
    // ptr_q = 0 favours the ALU, 1 favours the LSU when both request
    logic ptr_q, ptr_d;

    // round-robin pick between the two writeback requesters
    always_comb begin
        pick_lsu = i_lsu_valid && (!i_alu_valid || ptr_q);
        pick_alu = i_alu_valid && !pick_lsu;
    end

    // after each grant, favour the requester that was not granted
    always_comb begin
        ptr_d = ptr_q;
        if (alu_gnt)
            ptr_d = 1'b1;
        else if (lsu_gnt)
            ptr_d = 1'b0;
    end

    // pointer register, ALU favoured out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr_q <= 1'b0;
        else
            ptr_q <= ptr_d;
    end
`else
    // fixed priority: load data wins over ALU results
    always_comb begin
        pick_lsu = i_lsu_valid;
        pick_alu = i_alu_valid && !pick_lsu;
    end
`endif

    // grants are suppressed during reset so no handshake completes then
    always_comb begin
        lsu_gnt  = pick_lsu && !rst;
        alu_gnt  = pick_alu && !rst;
        wb_valid = lsu_gnt || alu_gnt;
        wb_rd    = lsu_gnt ? i_lsu_rd   : i_alu_rd;
        wb_data  = lsu_gnt ? i_lsu_data : i_alu_data;
    end

    // hazard check on sources and, for writing instructions, the destination
    always_comb begin
        iss_ready = !busy_q[i_iss_rs1] && !busy_q[i_iss_rs2] &&
                    !(i_iss_wr && busy_q[i_iss_rd]);
        iss_fire  = i_iss_valid && iss_ready && !rst;
    end

    // next state for the write stage, scoreboard and error flag
    always_comb begin
        busy_d       = busy_q;
        we_d         = 1'b0;
        wr_address_d = wr_address_q;
        wr_data_d    = wr_data_q;
        err_d        = err_q;

        // commit clears first so a (illegal) same-edge issue still sets the bit
        if (we_q)
            busy_d[wr_address_q] = 1'b0;
        if (iss_fire && i_iss_wr && (i_iss_rd != '0))
            busy_d[i_iss_rd] = 1'b1;
        busy_d[0] = 1'b0;

        // writes to x0 complete the handshake but never reach the register file
        if (wb_valid && (wb_rd != '0)) begin
            we_d         = 1'b1;
            wr_address_d = wb_rd;
            wr_data_d    = wb_data;
            if (!busy_q[wb_rd])
                err_d = 1'b1;
        end
    end

    // state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q       <= '0;
            we_q         <= 1'b0;
            wr_address_q <= '0;
            wr_data_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            we_q         <= we_d;
            wr_address_q <= wr_address_d;
            wr_data_q    <= wr_data_d;
            err_q        <= err_d;
        end
    end

    assign o_iss_ready  = iss_ready;
    assign o_alu_ready  = alu_gnt;
    assign o_lsu_ready  = lsu_gnt;
    assign o_we         = we_q;
    assign o_wr_address = wr_address_q;
    assign o_wr_data    = wr_data_q;
    assign o_busy       = busy_q;
    assign o_idle       = (busy_q == '0) && !we_q;
    assign o_err        = err_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios plus random traffic,
// checked every cycle against a behavioural scoreboard model.
module tb_regfile_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_iss_valid, i_iss_wr;
    logic [4:0]  i_iss_rs1, i_iss_rs2, i_iss_rd;
    logic        o_iss_ready;
    logic        i_alu_valid, i_lsu_valid;
    logic [4:0]  i_alu_rd, i_lsu_rd;
    logic [31:0] i_alu_data, i_lsu_data;
    logic        o_alu_ready, o_lsu_ready;
    logic        o_we;
    logic [4:0]  o_wr_address;
    logic [31:0] o_wr_data;
    logic [31:0] o_busy;
    logic        o_idle, o_err;

    regfile_wb_scheduler #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .i_iss_valid(i_iss_valid), .i_iss_rs1(i_iss_rs1), .i_iss_rs2(i_iss_rs2),
        .i_iss_rd(i_iss_rd), .i_iss_wr(i_iss_wr), .o_iss_ready(o_iss_ready),
        .i_alu_valid(i_alu_valid), .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
        .o_alu_ready(o_alu_ready),
        .i_lsu_valid(i_lsu_valid), .i_lsu_rd(i_lsu_rd), .i_lsu_data(i_lsu_data),
        .o_lsu_ready(o_lsu_ready),
        .o_we(o_we), .o_wr_address(o_wr_address), .o_wr_data(o_wr_data),
        .o_busy(o_busy), .o_idle(o_idle), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model: pending bits, the one write sitting in the output stage,
    // sticky error and which requester is favoured next
    bit          m_busy[32];
    bit          m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    bit          m_err;
    bit          m_fav_lsu;
    int          commits[$];
    bit          last_alu_rdy, last_lsu_rdy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] busy_vec();
        logic [31:0] v;
        for (int r = 0; r < 32; r++) v[r] = m_busy[r];
        return v;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_busy[r] = 0;
        m_we = 0; m_addr = '0; m_data = '0; m_err = 0; m_fav_lsu = 0;
    endtask

    task automatic clear_inputs();
        i_iss_valid = 0; i_iss_wr = 0; i_iss_rs1 = '0; i_iss_rs2 = '0; i_iss_rd = '0;
        i_alu_valid = 0; i_alu_rd = '0; i_alu_data = '0;
        i_lsu_valid = 0; i_lsu_rd = '0; i_lsu_data = '0;
    endtask

    // one clock: check all outputs mid-cycle, advance the model, then retire
    // whatever handshakes completed at the edge
    task automatic cycle();
        bit ga, gl, e_iss, fire;
        bit nb[32];
        logic [4:0]  w_rd;
        logic [31:0] w_data;
        @(negedge clk);
`ifdef REGFILE_WB_RR_ARB_EN
        gl = i_lsu_valid && (!i_alu_valid || m_fav_lsu);
`else
        gl = i_lsu_valid;
`endif
        ga = i_alu_valid && !gl;
        e_iss = !m_busy[i_iss_rs1] && !m_busy[i_iss_rs2] && !(i_iss_wr && m_busy[i_iss_rd]);
        fire = i_iss_valid && e_iss;
        chk("alu_ready", o_alu_ready, ga);
        chk("lsu_ready", o_lsu_ready, gl);
        chk("iss_ready", o_iss_ready, e_iss);
        chk("we", o_we, m_we);
        if (m_we) begin
            chk("wr_address", o_wr_address, m_addr);
            chk("wr_data", o_wr_data, m_data);
        end
        chk("busy", o_busy, busy_vec());
        chk("idle", o_idle, (busy_vec() == 0) && !m_we);
        chk("err", o_err, m_err);
        if (o_we === 1'b1) commits.push_back(int'(o_wr_address));
        last_alu_rdy = o_alu_ready;
        last_lsu_rdy = o_lsu_ready;

        nb = m_busy;
        if (m_we) nb[m_addr] = 0;
        if (fire && i_iss_wr && i_iss_rd != 0) nb[i_iss_rd] = 1;
        if (ga || gl) begin
            w_rd   = gl ? i_lsu_rd : i_alu_rd;
            w_data = gl ? i_lsu_data : i_alu_data;
            if (w_rd != 0 && !m_busy[w_rd]) m_err = 1;
            m_we = (w_rd != 0);
            if (w_rd != 0) begin
                m_addr = w_rd;
                m_data = w_data;
            end
            m_fav_lsu = ga;
        end else begin
            m_we = 0;
        end
        m_busy = nb;

        @(posedge clk);
        #1;
        if (ga) i_alu_valid = 0;
        if (gl) i_lsu_valid = 0;
        if (fire) i_iss_valid = 0;
    endtask

    // synchronous-looking reset pulse with reset-state checks while asserted
    task automatic apply_reset();
        clear_inputs();
        rst = 1;
        model_reset();
        i_alu_valid = 1; i_lsu_valid = 1; i_alu_rd = 5'd1; i_lsu_rd = 5'd2;
        @(negedge clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_we", o_we, 0);
        chk("rst_addr", o_wr_address, 0);
        chk("rst_data", o_wr_data, 0);
        chk("rst_err", o_err, 0);
        chk("rst_idle", o_idle, 1);
        chk("rst_alu_ready", o_alu_ready, 0);
        chk("rst_lsu_ready", o_lsu_ready, 0);
        @(posedge clk);
        #1;
        clear_inputs();
        rst = 0;
        commits.delete();
    endtask

    task automatic issue(input logic [4:0] rd);
        i_iss_valid = 1; i_iss_wr = 1; i_iss_rs1 = 5'd0; i_iss_rs2 = 5'd0; i_iss_rd = rd;
        cycle();
        chk("issue_fired", i_iss_valid, 0);
    endtask

    function automatic logic [4:0] pick_busy(input logic [4:0] avoid_a, input logic [4:0] avoid_b);
        logic [4:0] cand[$];
        for (int r = 1; r < 32; r++)
            if (m_busy[r] && r != avoid_a && r != avoid_b && !(m_we && r == m_addr))
                cand.push_back(5'(r));
        if (cand.size() == 0) return 5'd0;
        return cand[$urandom_range(cand.size() - 1)];
    endfunction

    initial begin
        int exp_order[$];
        int aq[$], lq[$];
        int budget;

        clear_inputs();
        rst = 0;
        #2;
        apply_reset();

        // random traffic; writebacks target pending registers so err stays low
        for (int n = 0; n < 400; n++) begin
            if (!i_iss_valid && $urandom_range(9) < 6) begin
                i_iss_valid = 1; i_iss_wr = $urandom_range(3) != 0;
                i_iss_rs1 = 5'($urandom); i_iss_rs2 = 5'($urandom); i_iss_rd = 5'($urandom);
            end
            if (!i_alu_valid && $urandom_range(1) == 1) begin
                i_alu_rd = pick_busy(i_lsu_valid ? i_lsu_rd : 5'd0, 5'd0);
                i_alu_data = $urandom; i_alu_valid = 1;
            end
            if (!i_lsu_valid && $urandom_range(1) == 1) begin
                i_lsu_rd = pick_busy(i_alu_valid ? i_alu_rd : 5'd0, 5'd0);
                i_lsu_data = $urandom; i_lsu_valid = 1;
            end
            cycle();
        end
        clear_inputs();
        for (int n = 0; n < 4; n++) cycle();
        chk("rand_err_clean", o_err, 0);
        chk("rand_drained_idle", o_idle, 1);

        // issue x5, RAW stall, ALU writeback, then the dependent issue fires
        apply_reset();
        issue(5'd5);
        chk("busy5_set", o_busy[5], 1);
        i_iss_valid = 1; i_iss_wr = 1; i_iss_rs1 = 5'd5; i_iss_rs2 = 5'd0; i_iss_rd = 5'd6;
        i_alu_valid = 1; i_alu_rd = 5'd5; i_alu_data = 32'hDEADBEEF;
        cycle();
        chk("alu_grant_x5", last_alu_rdy, 1);
        chk("raw_stall", i_iss_valid, 1);
        chk("we_x5", o_we, 1);
        chk("addr_x5", o_wr_address, 5);
        chk("data_x5", o_wr_data, 32'hDEADBEEF);
        cycle();
        chk("no_bypass_stall", i_iss_valid, 1);
        chk("busy5_clear", o_busy[5], 0);
        cycle();
        chk("dep_issue_fired", i_iss_valid, 0);
        chk("busy6_set", o_busy[6], 1);
        chk("err_clean", o_err, 0);

        // simultaneous requests, single pair
        apply_reset();
        issue(5'd3);
        issue(5'd4);
        commits.delete();
        i_alu_valid = 1; i_alu_rd = 5'd3; i_alu_data = 32'h33;
        i_lsu_valid = 1; i_lsu_rd = 5'd4; i_lsu_data = 32'h44;
        for (int n = 0; n < 4; n++) cycle();
`ifdef REGFILE_WB_RR_ARB_EN
        exp_order = '{3, 4};
`else
        exp_order = '{4, 3};
`endif
        chk("pair_count", commits.size(), exp_order.size());
        for (int k = 0; k < commits.size() && k < exp_order.size(); k++)
            chk("pair_order", commits[k], exp_order[k]);

        // four requests from each side kept continuously valid
        apply_reset();
        for (int r = 10; r < 18; r++) issue(5'(r));
        commits.delete();
        aq = '{10, 12, 14, 16};
        lq = '{11, 13, 15, 17};
        budget = 0;
        while ((aq.size() != 0 || lq.size() != 0 || i_alu_valid || i_lsu_valid) && budget < 30) begin
            if (!i_alu_valid && aq.size() != 0) begin
                i_alu_rd = 5'(aq.pop_front()); i_alu_data = $urandom; i_alu_valid = 1;
            end
            if (!i_lsu_valid && lq.size() != 0) begin
                i_lsu_rd = 5'(lq.pop_front()); i_lsu_data = $urandom; i_lsu_valid = 1;
            end
            cycle();
            budget++;
        end
        chk("burst_budget", budget < 30, 1);
        cycle();
        cycle();
`ifdef REGFILE_WB_RR_ARB_EN
        exp_order = '{10, 11, 12, 13, 14, 15, 16, 17};
`else
        exp_order = '{11, 13, 15, 17, 10, 12, 14, 16};
`endif
        chk("burst_count", commits.size(), exp_order.size());
        for (int k = 0; k < commits.size() && k < exp_order.size(); k++)
            chk("burst_order", commits[k], exp_order[k]);

        // x0 write is accepted but dropped; write to idle register flags err
        apply_reset();
        i_lsu_valid = 1; i_lsu_rd = 5'd0; i_lsu_data = 32'h1234;
        cycle();
        chk("x0_ready", last_lsu_rdy, 1);
        cycle();
        chk("x0_no_we", last_lsu_rdy == 0 && o_we == 0, 1);
        chk("x0_busy", o_busy, 0);
        chk("x0_err", o_err, 0);
        i_alu_valid = 1; i_alu_rd = 5'd7; i_alu_data = 32'h77;
        cycle();
        cycle();
        chk("err_set", o_err, 1);
        for (int n = 0; n < 3; n++) cycle();
        chk("err_sticky", o_err, 1);

        // asynchronous reset while a write to x9 sits in the output stage
        apply_reset();
        issue(5'd9);
        i_alu_valid = 1; i_alu_rd = 5'd9; i_alu_data = 32'h99;
        cycle();
        chk("pre_rst_we", o_we, 1);
        #2;
        rst = 1;
        i_lsu_valid = 1; i_lsu_rd = 5'd9;
        #1;
        chk("async_busy", o_busy, 0);
        chk("async_we", o_we, 0);
        chk("async_idle", o_idle, 1);
        chk("async_lsu_ready", o_lsu_ready, 0);
        model_reset();
        @(posedge clk);
        #1;
        clear_inputs();
        rst = 0;
        commits.delete();
        for (int n = 0; n < 3; n++) cycle();
        chk("post_rst_no_write", commits.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
- Owns the register file write port and tracks the register hazard scoreboard for the RV32I core.
- Two writeback requesters compete for the single write port: ALU (result) and LSU (load data).
- Arbitrates between them and drives the registered write port.
- Keeps one busy bit per architectural register, so issue stalls on RAW/WAW hazards until the producing write has committed.

Parameters:
- ADDR_WIDTH, 5, register address width (2^ADDR_WIDTH registers).
- DATA_WIDTH, 32, register data width.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- i_iss_valid  input  1  issue stage presents an instruction
- i_iss_rs1  input  ADDR_WIDTH  source register 1
- i_iss_rs2  input  ADDR_WIDTH  source register 2
- i_iss_rd  input  ADDR_WIDTH  destination register
- i_iss_wr  input  1  instruction writes rd
- o_iss_ready  output  1  no hazard; issue fires when valid && ready
- i_alu_valid  input  1  ALU writeback request
- i_alu_rd  input  ADDR_WIDTH  ALU destination
- i_alu_data  input  DATA_WIDTH  ALU result
- o_alu_ready  output  1  ALU request granted this cycle
- i_lsu_valid  input  1  LSU writeback request
- i_lsu_rd  input  ADDR_WIDTH  LSU destination
- i_lsu_data  input  DATA_WIDTH  load data
- o_lsu_ready  output  1  LSU request granted this cycle
- o_we  output  1  register file write enable
- o_wr_address  output  ADDR_WIDTH  register file write address
- o_wr_data  output  DATA_WIDTH  register file write data
- o_busy  output  2^ADDR_WIDTH  scoreboard bits, bit n = register n pending
- o_idle  output  1  no busy bits and o_we low
- o_err  output  1  sticky protocol-error flag

Behaviour:
- Reset (async, any cycle, including mid-operation):
  - o_busy=0, o_we=0, o_wr_address=0, o_wr_data=0, o_err=0, arbiter pointer to ALU.
  - Readies held 0 while rst high.
  - In-flight grants are discarded.
- Issue:
  - o_iss_ready = !busy[rs1] && !busy[rs2] && !(i_iss_wr && busy[rd]).
  - Register 0 is never busy.
  - Combinational; independent of i_iss_valid.
- Scoreboard set:
  - On issue fire with i_iss_wr=1 and rd!=0, busy[rd] is set at that edge.
- Scoreboard clear:
  - busy[o_wr_address] is cleared at the edge ending a cycle where o_we=1, i.e. when the register file commits.
  - No bypass: a dependent instruction issues the cycle after o_we, no earlier.
- Same-edge set and clear on one register:
  - Cannot occur legally, because issue stalls while busy.
  - If it does, clear is applied first and then set, so set wins.
- Arbitration (fixed priority, macro off):
  - LSU beats ALU.
  - At most one grant per cycle.
  - o_x_ready = granted && i_x_valid.
  - A request must hold valid/rd/data stable until ready.
- Write latency:
  - A grant at edge N loads the output register.
  - o_we=1 with rd/data during cycle N+1, for exactly one cycle.
  - Back-to-back grants produce o_we high on consecutive cycles.
- rd=0 writes:
  - Handshake completes normally.
  - o_we stays 0, no scoreboard change, no error.
- Error:
  - Granting a write whose rd!=0 has busy[rd]=0 sets o_err at that edge.
  - The write still proceeds.
  - o_err is cleared only by reset.
- o_idle = (o_busy==0) && !o_we.

Optional Feature:
- Macro: REGFILE_WB_RR_ARB_EN.
- Defined: round-robin arbitration. The pointer toggles to the non-granted requester after each grant. When both are continuously valid, grants alternate ALU, LSU, ALU, ... starting with ALU after reset.
- Undefined: fixed LSU priority as above. Pointer logic is absent.

Test Plan:
- Issue rd=5 (x5 not busy) -> o_busy[5]=1 next cycle. Subsequent issue with rs1=5 sees o_iss_ready=0.
- ALU writes rd=5 data 0xDEADBEEF -> o_alu_ready=1 that cycle. Next cycle o_we=1, o_wr_address=5, o_wr_data=0xDEADBEEF. The cycle after, busy[5]=0 and the rs1=5 issue fires.
- Both requesters valid, rd=3 and rd=4, macro off -> LSU granted first, then ALU. o_we high two consecutive cycles with addresses 4 then 3.
- Same with REGFILE_WB_RR_ARB_EN defined, both valid for 4 requests each -> grant order ALU, LSU, ALU, LSU, ...
- LSU write rd=0 data 0x1234 -> o_lsu_ready=1, o_we stays 0, o_busy unchanged. ALU write rd=7 with busy[7]=0 -> o_err=1 and stays 1.
- Issue rd=9, assert rst while a write to rd=9 sits in the output stage -> immediately o_busy=0, o_we=0, o_idle=1. After rst drops, no write is emitted.
